// File: rtl/dma_bus_arbiter.sv
// DMA sequencer and CPU/DMA memory-port arbiter with a one-deep request queue.
// Optional grant watchdog is built when ARB_WATCHDOG_EN is defined.
module dma_bus_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int LENGTH    = 12,
    parameter int WDT_LIMIT = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   dma_req,
    input  logic                   cpu_mem_busy,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    input  logic [WORD_SIZE-1:0]   cpu_addr,
    input  logic [4*WORD_SIZE-1:0] cpu_wdata,
    input  logic                   BR,
    input  logic                   dma_write,
    input  logic [WORD_SIZE-1:0]   dma_addr,
    input  logic [4*WORD_SIZE-1:0] dma_wdata,
    output logic                   cmd,
    output logic                   BG,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [WORD_SIZE-1:0]   mem_addr,
    output logic [4*WORD_SIZE-1:0] mem_wdata,
    output logic                   cpu_stall,
    output logic                   dma_done,
    output logic                   busy,
    output logic [WORD_SIZE-1:0]   xfer_count,
    output logic                   len_err,
    output logic                   wdt_err
);

    typedef enum logic [2:0] {IDLE, CMD, WAIT, GRANT, DONE} state_t;

    localparam logic [WORD_SIZE-1:0] LEN_W = WORD_SIZE'(LENGTH);

    state_t                 state_reg, state_next;
    logic                   pending_reg, pending_next;
    logic [WORD_SIZE-1:0]   xfer_reg, xfer_next;
    logic                   len_err_reg, len_err_next;
    logic                   wdt_err_reg, wdt_err_next;
    logic                   br_prev_reg;
    logic                   cmd_reg, bg_reg, done_reg;
    logic                   wdt_expired;

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(WDT_LIMIT + 1);
    logic [CW-1:0] wdt_cnt_reg;

    // Counts grant cycles; restarts from zero on every entry into GRANT.
    always_ff @(posedge CLK) begin
        if (RESET || state_reg != GRANT)
            wdt_cnt_reg <= '0;
        else
            wdt_cnt_reg <= wdt_cnt_reg + CW'(1);
    end

    assign wdt_expired = (state_reg == GRANT) && (wdt_cnt_reg == CW'(WDT_LIMIT - 1));
`else
    assign wdt_expired = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        xfer_next    = xfer_reg;
        len_err_next = len_err_reg;
        wdt_err_next = wdt_err_reg;

        if (state_reg != IDLE && dma_req)
            pending_next = 1'b1;

        case (state_reg)
            IDLE: begin
                if (dma_req || pending_reg) begin
                    state_next   = CMD;
                    pending_next = 1'b0;
                    xfer_next    = '0;
                    len_err_next = 1'b0;
                    wdt_err_next = 1'b0;
                end
            end
            CMD: state_next = WAIT;
            WAIT: begin
                if (BR && !cpu_mem_busy) begin
                    state_next = GRANT;
                end else if (!BR && br_prev_reg) begin
                    // Engine withdrew its request before being granted.
                    state_next   = DONE;
                    len_err_next = 1'b1;
                end
            end
            GRANT: begin
                if (dma_write && xfer_reg != '1)
                    xfer_next = xfer_reg + WORD_SIZE'(1);
                if (!BR) begin
                    state_next   = DONE;
                    len_err_next = (xfer_next != LEN_W);
                end else if (wdt_expired) begin
                    state_next   = DONE;
                    wdt_err_next = 1'b1;
                    len_err_next = (xfer_next != LEN_W);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= IDLE;
            pending_reg <= 1'b0;
            xfer_reg    <= '0;
            len_err_reg <= 1'b0;
            wdt_err_reg <= 1'b0;
            br_prev_reg <= 1'b0;
            cmd_reg     <= 1'b0;
            bg_reg      <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            xfer_reg    <= xfer_next;
            len_err_reg <= len_err_next;
            wdt_err_reg <= wdt_err_next;
            br_prev_reg <= BR;
            cmd_reg     <= (state_next == CMD);
            bg_reg      <= (state_next == GRANT);
            done_reg    <= (state_next == DONE);
        end
    end

    assign cmd        = cmd_reg;
    assign BG         = bg_reg;
    assign dma_done   = done_reg;
    assign busy       = (state_reg != IDLE);
    assign xfer_count = xfer_reg;
    assign len_err    = len_err_reg;
`ifdef ARB_WATCHDOG_EN
    assign wdt_err    = wdt_err_reg;
`else
    assign wdt_err    = 1'b0;
`endif

    // Memory port follows the registered grant with no extra latency.
    assign mem_addr  = bg_reg ? dma_addr  : cpu_addr;
    assign mem_wdata = bg_reg ? dma_wdata : cpu_wdata;
    assign mem_write = bg_reg ? dma_write : cpu_write;
    assign mem_read  = bg_reg ? 1'b0      : cpu_read;
    assign cpu_stall = bg_reg & (cpu_read | cpu_write);

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: vector table for contention/mux,
// hand sequences for basic, queued, short, abnormal, reset and watchdog cases.
module tb_dma_bus_arbiter;
    localparam int W = 16;
    localparam logic [W-1:0]   CADDR  = 16'h1234;
    localparam logic [W-1:0]   DADDR  = 16'hABCD;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET, dma_req, cpu_mem_busy, cpu_read, cpu_write, BR, dma_write;
    logic [W-1:0]   cpu_addr, dma_addr, mem_addr, xfer_count;
    logic [4*W-1:0] cpu_wdata, dma_wdata, mem_wdata;
    logic cmd, BG, mem_read, mem_write, cpu_stall, dma_done, busy, len_err, wdt_err;

    dma_bus_arbiter #(.WORD_SIZE(W), .LENGTH(12), .WDT_LIMIT(64)) dut (
        .CLK(CLK), .RESET(RESET), .dma_req(dma_req), .cpu_mem_busy(cpu_mem_busy),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .BR(BR), .dma_write(dma_write), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .cmd(cmd), .BG(BG), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_stall(cpu_stall), .dma_done(dma_done), .busy(busy),
        .xfer_count(xfer_count), .len_err(len_err), .wdt_err(wdt_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cmd_cnt = 0;
    int done_cnt = 0;

    always @(posedge CLK) begin
        if (cmd)      cmd_cnt  <= cmd_cnt + 1;
        if (dma_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_cmd(input string tag);
        dma_req = 1'b1;
        tick();
        chk1({tag, "_cmd"}, cmd, 1'b1);
        dma_req = 1'b0;
    endtask

    // From CMD: engine raises BR, holds grant for 'hold' cycles with 'beats' writes.
    task automatic serve(input string tag, input int hold, input int beats,
                         input int req_idx, input logic req_done);
        int bgc;
        BR = 1'b1;
        tick();
        tick();
        bgc = 0;
        for (int i = 0; i < hold; i++) begin
            bgc += int'(BG);
            dma_write = (i < beats);
            BR        = (i < hold - 1);
            dma_req   = (i == req_idx);
            tick();
        end
        dma_write = 1'b0;
        dma_req   = req_done;
        chkn({tag, "_bg_cycles"}, bgc, hold);
        chk1({tag, "_done"}, dma_done, 1'b1);
        chk1({tag, "_bg_off"}, BG, 1'b0);
        chkw({tag, "_xfer"}, xfer_count, W'(beats));
        chk1({tag, "_len_err"}, len_err, beats != 12);
        tick();
        dma_req = 1'b0;
        chk1({tag, "_done_1cyc"}, dma_done, 1'b0);
        chk1({tag, "_idle"}, busy, 1'b0);
    endtask

    typedef struct {
        logic req, mbusy, rd, wr, br, dw;
        logic e_cmd, e_bg, e_done, e_busy, e_stall, e_mrd, e_mwr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int c0, d0, bgc;

        //            req mb rd wr br dw | cmd bg done busy stall mrd mwr
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = tbl[2];
        tbl[6]  = tbl[2];
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

        RESET = 1'b1; dma_req = 1'b0; cpu_mem_busy = 1'b0; cpu_read = 1'b0;
        cpu_write = 1'b0; BR = 1'b0; dma_write = 1'b0;
        cpu_addr = '0; dma_addr = DADDR;
        cpu_wdata = '0; dma_wdata = 64'hDEAD_BEEF_0123_4567;
        tick();
        tick();
        chk1("rst_cmd", cmd, 1'b0);
        chk1("rst_bg", BG, 1'b0);
        chk1("rst_done", dma_done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_xfer", xfer_count, '0);
        chk1("rst_len_err", len_err, 1'b0);
        chk1("rst_wdt_err", wdt_err, 1'b0);
        chkw("rst_mem_addr", mem_addr, '0);
        RESET = 1'b0;
        cpu_addr = CADDR;
        cpu_wdata = 64'h1111_2222_3333_4444;
        tick();

        // CPU contention and memory mux, one row per cycle
        for (int i = 0; i < 12; i++) begin
            dma_req = tbl[i].req; cpu_mem_busy = tbl[i].mbusy; cpu_read = tbl[i].rd;
            cpu_write = tbl[i].wr; BR = tbl[i].br; dma_write = tbl[i].dw;
            tick();
            chk1($sformatf("row%0d_cmd", i), cmd, tbl[i].e_cmd);
            chk1($sformatf("row%0d_bg", i), BG, tbl[i].e_bg);
            chk1($sformatf("row%0d_done", i), dma_done, tbl[i].e_done);
            chk1($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
            chk1($sformatf("row%0d_stall", i), cpu_stall, tbl[i].e_stall);
            chk1($sformatf("row%0d_mem_read", i), mem_read, tbl[i].e_mrd);
            chk1($sformatf("row%0d_mem_write", i), mem_write, tbl[i].e_mwr);
            chkw($sformatf("row%0d_mem_addr", i), mem_addr, tbl[i].e_bg ? DADDR : CADDR);
            $display("vector %0d applied: cmd=%b BG=%b done=%b busy=%b", i, cmd, BG, dma_done, busy);
        end
        chkw("tbl_xfer", xfer_count, 16'd1);
        chk1("tbl_len_err", len_err, 1'b1);
        dma_req = 0; cpu_mem_busy = 0; cpu_read = 0; cpu_write = 0; BR = 0; dma_write = 0;

        // Basic 12-beat transfer
        c0 = cmd_cnt; d0 = done_cnt;
        start_cmd("basic");
        serve("basic", 13, 12, -1, 1'b0);
        tick();
        chkn("basic_cmd_pulses", cmd_cnt - c0, 1);
        chkn("basic_done_pulses", done_cnt - d0, 1);
        $display("basic transfer: xfer_count=%0d len_err=%b", xfer_count, len_err);

        // Queued requests: one during GRANT, one during DONE
        c0 = cmd_cnt; d0 = done_cnt;
        start_cmd("q1");
        serve("q1", 13, 12, 5, 1'b1);
        chk1("q_gap_cmd", cmd, 1'b0);
        tick();
        chk1("q_second_cmd", cmd, 1'b1);
        serve("q2", 13, 12, -1, 1'b0);
        tick(); tick(); tick();
        chkn("q_cmd_pulses", cmd_cnt - c0, 2);
        chkn("q_done_pulses", done_cnt - d0, 2);
        $display("queued requests: cmd pulses=%0d", cmd_cnt - c0);

        // Short transfer, then next cmd clears len_err
        start_cmd("short");
        serve("short", 13, 10, -1, 1'b0);
        dma_req = 1'b1;
        tick();
        dma_req = 1'b0;
        chk1("short_next_cmd", cmd, 1'b1);
        chk1("short_len_err_clr", len_err, 1'b0);
        chkw("short_xfer_clr", xfer_count, '0);
        serve("short2", 13, 12, -1, 1'b0);
        $display("short transfer sequence complete");

        // BR withdrawn while waiting
        start_cmd("abort");
        BR = 1'b0;
        tick(); tick();
        chk1("abort_hold_busy", busy, 1'b1);
        chk1("abort_hold_done", dma_done, 1'b0);
        BR = 1'b1; cpu_mem_busy = 1'b1;
        tick();
        chk1("abort_no_grant", BG, 1'b0);
        BR = 1'b0; cpu_mem_busy = 1'b0;
        tick();
        chk1("abort_done", dma_done, 1'b1);
        chk1("abort_bg", BG, 1'b0);
        chk1("abort_len_err", len_err, 1'b1);
        chkw("abort_xfer", xfer_count, '0);
        tick();
        chk1("abort_idle", busy, 1'b0);
        $display("abnormal BR drop handled");

        // Reset in the middle of a grant
        start_cmd("rst_mid");
        BR = 1'b1;
        tick(); tick();
        chk1("rst_mid_bg_on", BG, 1'b1);
        dma_write = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chkw("rst_mid_beats", xfer_count, 16'd6);
        d0 = done_cnt;
        RESET = 1'b1;
        tick();
        chk1("rst_mid_bg", BG, 1'b0);
        chk1("rst_mid_busy", busy, 1'b0);
        chkw("rst_mid_xfer", xfer_count, '0);
        chk1("rst_mid_done", dma_done, 1'b0);
        RESET = 1'b0; BR = 1'b0; dma_write = 1'b0;
        tick(); tick(); tick();
        chkn("rst_mid_no_done", done_cnt - d0, 0);
        $display("reset mid-grant handled");

        // BR held 100 cycles: watchdog cuts the grant when built in
        d0 = done_cnt;
        start_cmd("wdt");
        BR = 1'b1;
        tick();
        bgc = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            bgc += int'(BG);
        end
`ifdef ARB_WATCHDOG_EN
        chk1("wdt_err_set", wdt_err, 1'b1);
        chk1("wdt_idle", busy, 1'b0);
        BR = 1'b0;
        tick(); tick(); tick();
        chkn("wdt_bg_cycles", bgc, 64);
        chkn("wdt_done_pulses", done_cnt - d0, 1);
        start_cmd("wdt_clr");
        chk1("wdt_err_clr", wdt_err, 1'b0);
        BR = 1'b1; tick(); tick(); BR = 1'b0; tick(); tick();
`else
        chk1("wdt_err_tied", wdt_err, 1'b0);
        chk1("wdt_bg_held", BG, 1'b1);
        BR = 1'b0;
        tick(); tick(); tick();
        chkn("wdt_bg_cycles", bgc, 100);
        chkn("wdt_done_pulses", done_cnt - d0, 1);
`endif
        chk1("final_idle", busy, 1'b0);
        $display("long grant: BG cycles=%0d wdt_err=%b", bgc, wdt_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
